// File: rtl/adder16_arbiter.sv
// adder16_arbiter
//   Shares one 16-bit address adder (Adder16) between CPU requesters: PC
//   incrementer (index 0), SP push/pop, HL post-modify and ADD HL,rr.
//   Arbitrates (optional fixed PC priority plus round-robin), latches the
//   winner's operands into registers that drive the shared adder for one
//   cycle, then registers the adder result/flags with a one-hot done pulse.
//
// Ports
//   i_Clk, i_Reset        clock, synchronous active-high reset
//   i_Req                 per-requester request (held until its grant is seen)
//   i_ReqA/i_ReqB/i_ReqF  per-requester operands/flags, slot k at [16k +: 16] / [4k +: 4]
//   i_Stall               freeze the in-flight operation
//   i_Flush               abort the in-flight operation, no done pulse
//   o_AdderA/B/F          operand registers driving Adder16
//   i_AdderResult/i_AdderF  Adder16 outputs
//   o_Grant               one-hot owner of the adder this cycle
//   o_Busy                adder occupied
//   o_Done                one-hot single-cycle completion pulse
//   o_Result/o_F          registered sum and flags, held until next completion

module adder16_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter bit PC_PRIORITY = 1'b1
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [16*NUM_REQ-1:0]  i_ReqA,
    input  logic [16*NUM_REQ-1:0]  i_ReqB,
    input  logic [4*NUM_REQ-1:0]   i_ReqF,
    input  logic                   i_Stall,
    input  logic                   i_Flush,
    output logic [15:0]            o_AdderA,
    output logic [15:0]            o_AdderB,
    output logic [3:0]             o_AdderF,
    input  logic [15:0]            i_AdderResult,
    input  logic [3:0]             i_AdderF,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Busy,
    output logic [NUM_REQ-1:0]     o_Done,
    output logic [15:0]            o_Result,
    output logic [3:0]             o_F
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    logic [0:0]          state;
    logic [PW-1:0]       ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  done;
    logic [15:0]         op_a, op_b;
    logic [3:0]          op_f;
    logic [15:0]         result;
    logic [3:0]          flags;

    logic [NUM_REQ-1:0]  elig;
    logic                any_req;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       ptr_nxt;
    logic                found;
    int                  idx;

    // The current owner is masked while it holds the adder: its request is
    // still visible in the grant cycle and must not be served twice.
    always_comb begin
        elig    = i_Req & ((state == S_EXEC) ? ~grant : {NUM_REQ{1'b1}});
        any_req = |elig;
        win_idx = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        if (PC_PRIORITY && elig[0]) begin
            win_idx = '0;           // PC wins outright, pointer untouched
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (int'(ptr) + i) % NUM_REQ;
                if (!found && elig[idx]) begin
                    found   = 1'b1;
                    win_idx = PW'(idx);
                end
            end
            if (found)
                ptr_nxt = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            grant  <= '0;
            done   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_f   <= '0;
            result <= '0;
            flags  <= '0;
        end else if (i_Flush) begin
            // Abort: result registers keep the last completed value.
            state <= S_IDLE;
            grant <= '0;
            done  <= '0;
        end else if (state == S_EXEC && i_Stall) begin
            done <= '0;             // everything else holds
        end else begin
            if (state == S_EXEC) begin
                result <= i_AdderResult;
                flags  <= i_AdderF;
                done   <= grant;
            end else begin
                done <= '0;
            end
            if (any_req) begin
                // Back-to-back: a new winner is latched in the same edge the
                // previous op completes, so the adder sees no bubble.
                state <= S_EXEC;
                grant <= NUM_REQ'(1) << win_idx;
                ptr   <= ptr_nxt;
                op_a  <= i_ReqA[16*int'(win_idx) +: 16];
                op_b  <= i_ReqB[16*int'(win_idx) +: 16];
                op_f  <= i_ReqF[4*int'(win_idx) +: 4];
            end else begin
                state <= S_IDLE;
                grant <= '0;
            end
        end
    end

    assign o_AdderA = op_a;
    assign o_AdderB = op_b;
    assign o_AdderF = op_f;
    assign o_Grant  = grant;
    assign o_Busy   = (state == S_EXEC);
    assign o_Done   = done;
    assign o_Result = result;
    assign o_F      = flags;

endmodule

// File: tb/tb_adder16_arbiter.sv
// Bench for adder16_arbiter: dut 0 uses PC priority, dut 1 pure round-robin.
// A behavioural Adder16 (Z passed through, N=0, H = carry out of the low
// byte, C = carry out of bit 15) closes the loop for each instance.

module tb_adder16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;

    logic [3:0]  req  [2];
    logic [63:0] ra   [2];
    logic [63:0] rb   [2];
    logic [15:0] rf   [2];
    logic [15:0] aa   [2];
    logic [15:0] ab   [2];
    logic [3:0]  af   [2];
    logic [15:0] ares [2];
    logic [3:0]  aflg [2];
    logic [3:0]  gnt  [2];
    logic        busy [2];
    logic [3:0]  done [2];
    logic [15:0] res  [2];
    logic [3:0]  flg  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [19:0] add_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] f);
        logic [16:0] s;
        logic [8:0]  lo;
        s  = {1'b0, a} + {1'b0, b};
        lo = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        return {f[3], 1'b0, lo[8], s[16], s[15:0]};
    endfunction

    assign {aflg[0], ares[0]} = add_model(aa[0], ab[0], af[0]);
    assign {aflg[1], ares[1]} = add_model(aa[1], ab[1], af[1]);

    adder16_arbiter #(.NUM_REQ(4), .PC_PRIORITY(1'b1)) u_dut0 (
        .i_Clk(clk), .i_Reset(rst), .i_Req(req[0]), .i_ReqA(ra[0]), .i_ReqB(rb[0]),
        .i_ReqF(rf[0]), .i_Stall(stall), .i_Flush(flush), .o_AdderA(aa[0]),
        .o_AdderB(ab[0]), .o_AdderF(af[0]), .i_AdderResult(ares[0]), .i_AdderF(aflg[0]),
        .o_Grant(gnt[0]), .o_Busy(busy[0]), .o_Done(done[0]), .o_Result(res[0]), .o_F(flg[0])
    );

    adder16_arbiter #(.NUM_REQ(4), .PC_PRIORITY(1'b0)) u_dut1 (
        .i_Clk(clk), .i_Reset(rst), .i_Req(req[1]), .i_ReqA(ra[1]), .i_ReqB(rb[1]),
        .i_ReqF(rf[1]), .i_Stall(1'b0), .i_Flush(1'b0), .o_AdderA(aa[1]),
        .o_AdderB(ab[1]), .o_AdderF(af[1]), .i_AdderResult(ares[1]), .i_AdderF(aflg[1]),
        .o_Grant(gnt[1]), .o_Busy(busy[1]), .o_Done(done[1]), .o_Result(res[1]), .o_F(flg[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int d, input int k, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] f);
        ra[d][16*k +: 16] = a;
        rb[d][16*k +: 16] = b;
        rf[d][4*k +: 4]   = f;
    endtask

    int ord[4];

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; ra[d] = '0; rb[d] = '0; rf[d] = '0;
        end
        tick(); tick();
        // reset state
        chk("rst_gnt",  32'(gnt[0]),  32'h0);
        chk("rst_done", 32'(done[0]), 32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_res",  32'(res[0]),  32'h0);
        chk("rst_f",    32'(flg[0]),  32'h0);
        chk("rst_opa",  32'(aa[0]),   32'h0);
        rst = 1'b0;

        // single op on requester 2: 0x00FF + 1
        set_op(0, 2, 16'h00FF, 16'h0001, 4'h0);
        req[0] = 4'b0100;
        tick();
        chk("one_gnt",  32'(gnt[0]),  32'h4);
        chk("one_busy", 32'(busy[0]), 32'h1);
        chk("one_opa",  32'(aa[0]),   32'h00FF);
        chk("one_done0",32'(done[0]), 32'h0);
        req[0] = '0;
        tick();
        chk("one_done", 32'(done[0]), 32'h4);
        chk("one_res",  32'(res[0]),  32'h0100);
        chk("one_f",    32'(flg[0]),  32'h2);
        chk("one_idle", 32'(gnt[0]),  32'h0);
        tick();
        chk("one_pulse",32'(done[0]), 32'h0);
        chk("one_hold", 32'(res[0]),  32'h0100);

        // wrap on requester 3, Z passed through
        set_op(0, 3, 16'hFFFF, 16'h0001, 4'h8);
        req[0] = 4'b1000;
        tick(); req[0] = '0; tick();
        chk("wrap1_res", 32'(res[0]), 32'h0000);
        chk("wrap1_f",   32'(flg[0]), 32'hB);
        set_op(0, 3, 16'h8000, 16'h8000, 4'h0);
        req[0] = 4'b1000;
        tick(); req[0] = '0; tick();
        chk("wrap2_res", 32'(res[0]), 32'h0000);
        chk("wrap2_f",   32'(flg[0]), 32'h1);

        // PC priority, all four held, each drops at its grant: 0,1,2,3
        for (int k = 0; k < 4; k++) set_op(0, k, 16'(k), 16'(k), 4'h0);
        req[0] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("pc_gnt", 32'(gnt[0]), 32'(1 << k));
            chk("pc_busy", 32'(busy[0]), 32'h1);
            if (k > 0) begin
                chk("pc_done", 32'(done[0]), 32'(1 << (k - 1)));
                chk("pc_res",  32'(res[0]),  32'(2 * (k - 1)));
            end
            req[0][k] = 1'b0;
        end
        tick();
        chk("pc_done3", 32'(done[0]), 32'h8);
        chk("pc_res3",  32'(res[0]),  32'h6);
        chk("pc_gnt_end", 32'(gnt[0]), 32'h0);

        // back-to-back requesters 1 and 2 (pointer is 0 here)
        set_op(0, 1, 16'h1234, 16'h1111, 4'h0);
        set_op(0, 2, 16'h0F80, 16'h0080, 4'h0);
        req[0] = 4'b0110;
        tick();
        chk("b2b_gnt1", 32'(gnt[0]), 32'h2);
        chk("b2b_busy1",32'(busy[0]), 32'h1);
        req[0][1] = 1'b0;
        tick();
        chk("b2b_gnt2", 32'(gnt[0]),  32'h4);
        chk("b2b_busy2",32'(busy[0]), 32'h1);
        chk("b2b_done1",32'(done[0]), 32'h2);
        chk("b2b_res1", 32'(res[0]),  32'h2345);
        chk("b2b_f1",   32'(flg[0]),  32'h0);
        req[0][2] = 1'b0;
        tick();
        chk("b2b_done2",32'(done[0]), 32'h4);
        chk("b2b_res2", 32'(res[0]),  32'h1000);
        chk("b2b_f2",   32'(flg[0]),  32'h2);
        chk("b2b_busy3",32'(busy[0]), 32'h0);

        // a request held through its grant is a new op after one idle cycle
        set_op(0, 0, 16'h0010, 16'h0001, 4'h0);
        req[0] = 4'b0001;
        tick();
        chk("held_gnt", 32'(gnt[0]), 32'h1);
        tick();
        chk("held_done",32'(done[0]), 32'h1);
        chk("held_mask",32'(gnt[0]),  32'h0);
        tick();
        chk("held_regnt",32'(gnt[0]), 32'h1);
        req[0] = '0;
        tick();
        chk("held_done2",32'(done[0]), 32'h1);
        tick();

        // stall for 3 cycles in EXEC
        set_op(0, 0, 16'h1000, 16'h0002, 4'h0);
        req[0] = 4'b0001;
        tick();
        req[0] = '0;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_gnt",  32'(gnt[0]),  32'h1);
            chk("stall_done", 32'(done[0]), 32'h0);
            chk("stall_busy", 32'(busy[0]), 32'h1);
        end
        stall = 1'b0;
        tick();
        chk("stall_fin",  32'(done[0]), 32'h1);
        chk("stall_res",  32'(res[0]),  32'h1002);

        // flush mid-op
        set_op(0, 1, 16'h0005, 16'h0005, 4'h0);
        req[0] = 4'b0010;
        tick();
        chk("fl_gnt", 32'(gnt[0]), 32'h2);
        req[0] = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_gnt0", 32'(gnt[0]),  32'h0);
        chk("fl_done", 32'(done[0]), 32'h0);
        chk("fl_busy", 32'(busy[0]), 32'h0);
        chk("fl_res",  32'(res[0]),  32'h1002);
        tick();
        chk("fl_done2",32'(done[0]), 32'h0);

        // pure round-robin: serve 1 first (ptr -> 2), then 1111 -> 2,3,0,1
        set_op(1, 1, 16'h0010, 16'h0020, 4'h0);
        req[1] = 4'b0010;
        tick(); req[1] = '0; tick();
        chk("rr_done1", 32'(done[1]), 32'h2);
        chk("rr_res1",  32'(res[1]),  32'h0030);
        ord = '{2, 3, 0, 1};
        req[1] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt[1]), 32'(1 << ord[k]));
            req[1][ord[k]] = 1'b0;
        end
        tick();
        chk("rr_done_last", 32'(done[1]), 32'h2);

        // reset mid-op on both instances
        set_op(0, 2, 16'h0001, 16'h0001, 4'h0);
        req[0] = 4'b0100;
        req[1] = 4'b0010;
        tick();
        chk("rm_gnt0", 32'(gnt[0]), 32'h4);
        chk("rm_gnt1", 32'(gnt[1]), 32'h2);
        req[0] = '0; req[1] = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_gnt",  32'(gnt[0]),  32'h0);
        chk("rm_done", 32'(done[0]), 32'h0);
        chk("rm_res",  32'(res[0]),  32'h0);
        chk("rm_f",    32'(flg[0]),  32'h0);
        chk("rm_done1",32'(done[1]), 32'h0);
        // pointer back to 0: 1001 picks 0 (a pointer left at 2 would pick 3)
        req[1] = 4'b1001;
        tick();
        chk("rm_ptr", 32'(gnt[1]), 32'h1);
        req[1] = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
